// File: rtl/softmax_n.sv
// softmax_n: N-class fixed-point softmax over a serial valid/ready stream.
//   Scores arrive one per accept (class index = arrival order). After a frame
//   of N_CLASS scores the running max is subtracted, exp is approximated by a
//   base-2 LUT, the sum is accumulated, and one probability per class is
//   produced by a restoring divider.
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_data      : signed Q(IN_W-FRAC).FRAC scores
//   out_valid/out_ready/out_data   : unsigned Q0.OUT_W probability
//   out_index, out_last            : class index, final class of frame
//   busy                           : high unless idle in LOAD with no scores held
// Optional: define SOFTMAX_ARGMAX_EN to add out_argmax (first index of the max).
module softmax_n #(
  parameter int N_CLASS = 4,
  parameter int IN_W    = 16,
  parameter int FRAC    = 8,
  parameter int OUT_W   = 16,
  localparam int IDX_W  = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
`ifdef SOFTMAX_ARGMAX_EN
  output logic [IDX_W-1:0] out_argmax,
`endif
  output logic             busy
);

  localparam int SUM_W  = 16 + $clog2(N_CLASS) + 1;
  localparam int REM_W  = SUM_W + 1;
  localparam int PROD_W = IN_W + 19;
  localparam int DC_W   = $clog2(OUT_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASS - 1);
  localparam logic [DC_W-1:0]  DIV_LAST = DC_W'(OUT_W);
  localparam logic signed [IN_W-1:0]   MOST_NEG = {1'b1, {(IN_W-1){1'b0}}};
  // log2(e) in Q.16
  localparam logic signed [PROD_W-1:0] LOG2E = PROD_W'(94548);

  typedef enum logic [1:0] {LOAD, EXP, DIV, OUT} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic signed [IN_W-1:0]  max_r;
  logic signed [IN_W-1:0]  score_buf [N_CLASS];
  logic [15:0]             e_buf [N_CLASS];
  logic [SUM_W-1:0]        sum;
  logic [REM_W-1:0]        rem;
  logic [OUT_W-1:0]        quo;
  logic [DC_W-1:0]         div_cnt;
`ifdef SOFTMAX_ARGMAX_EN
  logic [IDX_W-1:0]        arg_r;
`endif

  function automatic logic [15:0] exp_lut(input logic [3:0] f);
    logic [15:0] v;
    case (f)
      4'd0:  v = 16'd32768;
      4'd1:  v = 16'd34219;
      4'd2:  v = 16'd35734;
      4'd3:  v = 16'd37316;
      4'd4:  v = 16'd38968;
      4'd5:  v = 16'd40693;
      4'd6:  v = 16'd42495;
      4'd7:  v = 16'd44376;
      4'd8:  v = 16'd46341;
      4'd9:  v = 16'd48393;
      4'd10: v = 16'd50535;
      4'd11: v = 16'd52773;
      4'd12: v = 16'd55109;
      4'd13: v = 16'd57549;
      4'd14: v = 16'd60097;
      default: v = 16'd62757;
    endcase
    return v;
  endfunction

  // exp path for class idx: t = floor(d*log2e), k = integer part, f = top fraction nibble
  logic signed [IN_W:0]       d_w;
  logic signed [PROD_W-1:0]   d_ext;
  logic signed [PROD_W-1:0]   prod;
  logic signed [PROD_W-1:0]   t_fix;
  logic signed [PROD_W-1:0]   k_neg;
  logic signed [PROD_W-1:0]   k_val;
  logic [3:0]                 f_idx;
  logic [15:0]                e_val;

  always_comb begin
    d_w   = {score_buf[idx][IN_W-1], score_buf[idx]} - {max_r[IN_W-1], max_r};
    d_ext = PROD_W'(d_w);
    prod  = d_ext * LOG2E;
    t_fix = prod >>> 16;
    k_neg = t_fix >>> FRAC;
    k_val = -k_neg;
    f_idx = t_fix[FRAC-1 -: 4];
    e_val = (|k_val[PROD_W-1:4]) ? '0 : (exp_lut(f_idx) >> k_val[3:0]);
  end

  // restoring divider step; the first of OUT_W+1 steps yields the 2^OUT_W bit
  logic             rem_ge;
  logic [REM_W-1:0] rem_diff;
  logic [OUT_W:0]   quo_next;

  always_comb begin
    rem_ge   = rem >= {1'b0, sum};
    rem_diff = rem_ge ? (rem - {1'b0, sum}) : rem;
    quo_next = {quo, rem_ge};
  end

  always_comb begin
    busy = (state != LOAD) || (cnt != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LOAD;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      cnt       <= '0;
      idx       <= '0;
      max_r     <= MOST_NEG;
      sum       <= '0;
      rem       <= '0;
      quo       <= '0;
      div_cnt   <= '0;
      for (int unsigned j = 0; j < N_CLASS; j++) begin
        score_buf[j] <= '0;
        e_buf[j]     <= '0;
      end
`ifdef SOFTMAX_ARGMAX_EN
      arg_r      <= '0;
      out_argmax <= '0;
`endif
    end else begin
      unique case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            score_buf[cnt] <= in_data;
            if ($signed(in_data) > max_r) begin
              max_r <= in_data;
`ifdef SOFTMAX_ARGMAX_EN
              arg_r <= cnt;
`endif
            end
            if (cnt == LAST_IDX) begin
              cnt      <= '0;
              idx      <= '0;
              sum      <= '0;
              in_ready <= 1'b0;
              state    <= EXP;
`ifdef SOFTMAX_ARGMAX_EN
              out_argmax <= ($signed(in_data) > max_r) ? cnt : arg_r;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        EXP: begin
          e_buf[idx] <= e_val;
          sum        <= sum + SUM_W'(e_val);
          if (idx == LAST_IDX) begin
            idx     <= '0;
            // with one class, e_buf[0] is being written on this same edge
            rem     <= REM_W'((N_CLASS == 1) ? e_val : e_buf[0]);
            quo     <= '0;
            div_cnt <= '0;
            state   <= DIV;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DIV: begin
          rem <= rem_diff << 1;
          quo <= quo_next[OUT_W-1:0];
          if (div_cnt == DIV_LAST) begin
            out_data  <= quo_next[OUT_W] ? '1 : quo_next[OUT_W-1:0];
            out_valid <= 1'b1;
            out_index <= idx;
            out_last  <= (idx == LAST_IDX);
            state     <= OUT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (idx == LAST_IDX) begin
              idx      <= '0;
              max_r    <= MOST_NEG;
              sum      <= '0;
              in_ready <= 1'b1;
              state    <= LOAD;
`ifdef SOFTMAX_ARGMAX_EN
              arg_r    <= '0;
`endif
            end else begin
              idx     <= idx + 1'b1;
              rem     <= REM_W'(e_buf[idx + 1'b1]);
              quo     <= '0;
              div_cnt <= '0;
              state   <= DIV;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_n.sv
module tb_softmax_n;

  localparam int OUT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        rst_n;
  logic        sel;      // 0: 4-class DUT, 1: 2-class DUT
  logic        iv;
  logic        oready;
  logic [15:0] din;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, out_last4, busy4;
  logic [15:0] out_data4;
  logic [1:0]  out_index4;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_last2, busy2;
  logic [15:0] out_data2;
  logic [0:0]  out_index2;
`ifdef SOFTMAX_ARGMAX_EN
  logic [1:0]  out_argmax4;
  logic [0:0]  out_argmax2;
`endif

  assign in_valid4  = iv & ~sel;
  assign in_valid2  = iv & sel;
  assign out_ready4 = oready & ~sel;
  assign out_ready2 = oready & sel;

  softmax_n #(.N_CLASS(4), .IN_W(16), .FRAC(8), .OUT_W(OUT_W)) u_dut4 (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(din),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_index(out_index4), .out_last(out_last4),
`ifdef SOFTMAX_ARGMAX_EN
    .out_argmax(out_argmax4),
`endif
    .busy(busy4)
  );

  softmax_n #(.N_CLASS(2), .IN_W(16), .FRAC(8), .OUT_W(OUT_W)) u_dut2 (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(din),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_index(out_index2), .out_last(out_last2),
`ifdef SOFTMAX_ARGMAX_EN
    .out_argmax(out_argmax2),
`endif
    .busy(busy2)
  );

  logic        m_in_ready, m_out_valid, m_out_last, m_busy;
  logic [15:0] m_out_data;
  logic [1:0]  m_out_index;

  always_comb begin
    if (sel) begin
      m_in_ready  = in_ready2;
      m_out_valid = out_valid2;
      m_out_last  = out_last2;
      m_busy      = busy2;
      m_out_data  = out_data2;
      m_out_index = {1'b0, out_index2};
    end else begin
      m_in_ready  = in_ready4;
      m_out_valid = out_valid4;
      m_out_last  = out_last4;
      m_busy      = busy4;
      m_out_data  = out_data4;
      m_out_index = out_index4;
    end
  end

  typedef struct packed {
    logic [3:0][15:0] s;
    logic [3:0][15:0] q;
    logic [1:0]       am;
  } vec_t;

  vec_t vt [5];

  function automatic vec_t mk(input logic [15:0] s0, input logic [15:0] s1,
                              input logic [15:0] s2, input logic [15:0] s3,
                              input logic [15:0] q0, input logic [15:0] q1,
                              input logic [15:0] q2, input logic [15:0] q3,
                              input logic [1:0] am);
    vec_t v;
    v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
    v.q[0] = q0; v.q[1] = q1; v.q[2] = q2; v.q[3] = q3;
    v.am   = am;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Presents n scores back to back; acc returns the cycle stamp of the last accept edge.
  task automatic send_frame(input int n, input logic [3:0][15:0] s, output int acc);
    for (int k = 0; k < n; k++) begin
      int guard;
      guard = 0;
      while (!m_in_ready && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      if (!m_in_ready) check("in_ready_timeout", 32'(m_in_ready), 32'd1);
      iv  = 1'b1;
      din = s[k];
      @(posedge clk); #1;
    end
    iv  = 1'b0;
    acc = cyc;
  endtask

  // Collects n outputs; stall_idx selects a class held 10 cycles with out_ready low.
  task automatic recv_frame(input int n, input logic [3:0][15:0] q, input int ref_cyc,
                            input int lat0, input int stall_idx);
    int refc;
    refc = ref_cyc;
    for (int c = 0; c < n; c++) begin
      int guard;
      guard = 0;
      while (!m_out_valid && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      check("out_valid_seen", 32'(m_out_valid), 32'd1);
      check("latency", 32'(cyc - refc), (c == 0) ? 32'(lat0) : 32'(OUT_W + 1));
      check("out_data", 32'(m_out_data), 32'(q[c]));
      check("out_index", 32'(m_out_index), 32'(c));
      check("out_last", 32'(m_out_last), 32'(c == n - 1));
      check("in_ready_low", 32'(m_in_ready), 32'd0);
      if (c == stall_idx) begin
        for (int s = 0; s < 10; s++) begin
          @(posedge clk); #1;
          check("stall_valid", 32'(m_out_valid), 32'd1);
          check("stall_data", 32'(m_out_data), 32'(q[c]));
          check("stall_index", 32'(m_out_index), 32'(c));
          check("stall_in_ready", 32'(m_in_ready), 32'd0);
        end
      end
      oready = 1'b1;
      @(posedge clk); #1;
      oready = 1'b0;
      refc = cyc;
      check("valid_drop", 32'(m_out_valid), 32'd0);
    end
    check("in_ready_back", 32'(m_in_ready), 32'd1);
    check("busy_idle", 32'(m_busy), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 32'(m_in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(m_out_valid), 32'd0);
    check({tag, "_busy"}, 32'(m_busy), 32'd0);
    check({tag, "_out_data"}, 32'(m_out_data), 32'd0);
    check({tag, "_out_index"}, 32'(m_out_index), 32'd0);
    check({tag, "_out_last"}, 32'(m_out_last), 32'd0);
  endtask

  initial begin
    int acc;
    logic [3:0][15:0] s2;
    logic [3:0][15:0] q2;

    sel    = 1'b0;
    iv     = 1'b0;
    oready = 1'b0;
    din    = '0;
    rst_n  = 1'b0;

    //          scores (Q8.8)                              expected probabilities     argmax
    vt[0] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd16384, 16'd16384, 16'd16384, 16'd16384, 2'd0);
    vt[1] = mk(16'h0000, 16'h9C00, 16'h9C00, 16'h9C00, 16'd65535, 16'd0,     16'd0,     16'd0,     2'd0);
    vt[2] = mk(16'hFF00, 16'hFF00, 16'h0000, 16'hFF00, 16'd11244, 16'd11244, 16'd31803, 16'd11244, 2'd2);
    vt[3] = mk(16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'd0,     16'd0,     16'd0,     16'd65535, 2'd3);
    vt[4] = mk(16'h0100, 16'h0300, 16'h0300, 16'hFE00, 16'd4002,  16'd30666, 16'd30666, 16'd201,   2'd1);

    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0; #1;
    check_idle("rst4");
`ifdef SOFTMAX_ARGMAX_EN
    check("rst4_argmax", 32'(out_argmax4), 32'd0);
`endif
    sel = 1'b1; #1;
    check_idle("rst2");
    sel = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      send_frame(4, vt[v].s, acc);
      check("in_ready_drop", 32'(m_in_ready), 32'd0);
      check("busy_frame", 32'(m_busy), 32'd1);
      recv_frame(4, vt[v].q, acc, 21, -1);
`ifdef SOFTMAX_ARGMAX_EN
      check("out_argmax", 32'(out_argmax4), 32'(vt[v].am));
`endif
    end

    // backpressure on class 1
    send_frame(4, vt[2].s, acc);
    recv_frame(4, vt[2].q, acc, 21, 1);

    // reset after two of four scores, then a fresh frame
    s2 = '0;
    s2[0] = 16'h7FFF;
    s2[1] = 16'h7FFF;
    send_frame(2, s2, acc);
    check("partial_busy", 32'(m_busy), 32'd1);
    rst_n = 1'b0;
    #2;
    check("midrst_in_ready", 32'(m_in_ready), 32'd1);
    check("midrst_busy", 32'(m_busy), 32'd0);
    check("midrst_out_valid", 32'(m_out_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(4, vt[4].s, acc);
    recv_frame(4, vt[4].q, acc, 21, -1);

    // two-class instance
    sel = 1'b1;
    #1;
    s2 = '0;
    q2 = '0;
    s2[0] = 16'h0000;
    s2[1] = 16'hFF00;
    q2[0] = 16'd48418;
    q2[1] = 16'd17117;
    send_frame(2, s2, acc);
    recv_frame(2, q2, acc, 19, -1);
`ifdef SOFTMAX_ARGMAX_EN
    check("out_argmax2", 32'(out_argmax2), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
